// File: rtl/counter_req_arbiter.sv
// counter_req_arbiter: round-robin arbiter sharing the counter between a byte-strobed port A and a full-word port B
module counter_req_arbiter #(
  parameter int BITS = 16,
  localparam int NSTRB = BITS / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             a_valid,
  input  logic             a_we,
  input  logic [NSTRB-1:0] a_wstrb,
  input  logic [BITS-1:0]  a_wdata,
  output logic             a_ready,
  output logic [BITS-1:0]  a_rdata,
  input  logic             b_valid,
  input  logic             b_we,
  input  logic [BITS-1:0]  b_wdata,
  output logic             b_ready,
  output logic [BITS-1:0]  b_rdata,
  input  logic [BITS-1:0]  cnt_value,
  output logic             cnt_load,
  output logic [BITS-1:0]  cnt_load_val,
  output logic             cnt_inc,
  output logic             busy,
  output logic [1:0]       grant
);
  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;
  state_t state, state_nx;
  logic rr_ptr, owner, we_q, pick;
  logic [BITS-1:0] wdata_q, merged;
  logic [NSTRB-1:0] wstrb_q;
  assign pick = a_valid & b_valid ? rr_ptr : b_valid;
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (a_valid | b_valid ? SERVE : IDLE) : state == SERVE ? DONE : IDLE;
  end
  // rr_ptr prefers the port that was not just served
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      grant <= 2'b00;
    end else begin
      state <= state_nx;
      if (state == IDLE && (a_valid | b_valid)) begin
        owner <= pick;
        we_q <= pick ? b_we : a_we;
        wdata_q <= pick ? b_wdata : a_wdata;
        wstrb_q <= a_wstrb;
        grant <= pick ? 2'b10 : 2'b01;
      end
      if (state == SERVE && owner) b_rdata <= cnt_value;
      if (state == SERVE && !owner) a_rdata <= cnt_value;
      if (state == DONE) rr_ptr <= ~owner;
    end
  end
  for (genvar i = 0; i < NSTRB; i++) begin : g_byte
    assign merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : cnt_value[8*i +: 8];
  end
  assign cnt_load = state == SERVE && we_q && (owner || |wstrb_q);
  assign cnt_load_val = owner ? wdata_q : merged;
  assign cnt_inc = run & ~cnt_load;
  assign busy = state != IDLE;
  assign a_ready = state == DONE && !owner;
  assign b_ready = state == DONE && owner;
endmodule

// File: tb/tb_counter_req_arbiter.sv
// tb_counter_req_arbiter: directed and random requests checked against a transaction-timeline model
module tb_counter_req_arbiter;
  localparam int BITS = 16;
  localparam int NSTRB = 2;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0;
  logic a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
  logic [NSTRB-1:0] a_wstrb = '0;
  logic [BITS-1:0] a_wdata = '0, b_wdata = '0, ctr = '0;
  logic a_ready, b_ready, cnt_load, cnt_inc, busy;
  logic [BITS-1:0] a_rdata, b_rdata, cnt_load_val;
  logic [1:0] grant;
  int checks = 0, failures = 0;
  bit m_busy, m_own, m_we, m_rr, a_seen, b_seen;
  int m_age;
  logic [BITS-1:0] m_wd, m_ard, m_brd;
  logic [NSTRB-1:0] m_ws;
  logic [1:0] m_grant;

  counter_req_arbiter #(.BITS(BITS)) dut (
    .clk(clk), .reset(reset), .run(run),
    .a_valid(a_valid), .a_we(a_we), .a_wstrb(a_wstrb), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_we(b_we), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rdata(b_rdata),
    .cnt_value(ctr), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
    .cnt_inc(cnt_inc), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  function automatic logic [BITS-1:0] merge(logic [BITS-1:0] cur, logic [BITS-1:0] wd, logic [NSTRB-1:0] ws);
    logic [BITS-1:0] mask = '0;
    for (int i = 0; i < NSTRB; i++) if (ws[i]) mask |= 16'hFF << (8 * i);
    return (cur & ~mask) | (wd & mask);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_rr = 0; m_grant = 2'b00; m_ard = '0; m_brd = '0;
  endtask

  // one clock: check mid-cycle, advance the model at the edge, then let the counter react
  task automatic step();
    bit serve, done, ld;
    logic [BITS-1:0] val;
    #4;
    serve = m_busy && m_age == 1;
    done = m_busy && m_age == 2;
    ld = serve && m_we && (m_own || m_ws != 0);
    val = m_own ? m_wd : merge(ctr, m_wd, m_ws);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("grant", 32'(grant), 32'(m_grant));
    chk("cnt_load", 32'(cnt_load), 32'(ld));
    if (ld) chk("cnt_load_val", 32'(cnt_load_val), 32'(val));
    chk("cnt_inc", 32'(cnt_inc), 32'(run && !ld));
    chk("a_ready", 32'(a_ready), 32'(done && !m_own));
    chk("b_ready", 32'(b_ready), 32'(done && m_own));
    chk("a_rdata", 32'(a_rdata), 32'(m_ard));
    chk("b_rdata", 32'(b_rdata), 32'(m_brd));
    a_seen = a_ready;
    b_seen = b_ready;
    @(posedge clk);
    if (reset) model_reset();
    else if (!m_busy) begin
      if (a_valid || b_valid) begin
        m_own = (a_valid && b_valid) ? m_rr : b_valid;
        m_we = m_own ? b_we : a_we;
        m_wd = m_own ? b_wdata : a_wdata;
        m_ws = a_wstrb;
        m_busy = 1; m_age = 1;
        m_grant = m_own ? 2'b10 : 2'b01;
      end
    end else if (m_age == 1) begin
      if (m_own) m_brd = ctr; else m_ard = ctr;
      m_age = 2;
    end else begin
      m_busy = 0;
      m_rr = !m_own;
    end
    #1;
    ctr = ld ? val : run ? ctr + 1'b1 : ctr;
  endtask

  task automatic wait_ready(bit port_b);
    int n = 0;
    do begin step(); n++; end while (!(port_b ? b_seen : a_seen) && n < 8);
    checks++;
    if (!(port_b ? b_seen : a_seen)) begin
      failures++;
      $error("FAIL ready_timeout port_b=%0d got=0 exp=1", port_b);
    end
    if (port_b) b_valid = 0; else a_valid = 0;
  endtask

  task automatic req_a(bit we, logic [NSTRB-1:0] s, logic [BITS-1:0] d);
    a_valid = 1; a_we = we; a_wstrb = s; a_wdata = d;
    wait_ready(0);
  endtask

  task automatic req_b(bit we, logic [BITS-1:0] d);
    b_valid = 1; b_we = we; b_wdata = d;
    wait_ready(1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step();
    reset = 0;
    step();
    ctr = 16'h0042;
    req_a(1, 2'b11, 16'h1234);
    chk("t1_a_rdata", 32'(a_rdata), 32'h0042);
    step();
    ctr = 16'h00CD;
    req_a(1, 2'b10, 16'hAB00);
    chk("t2_a_rdata", 32'(a_rdata), 32'h00CD);
    req_a(1, 2'b00, 16'h5555);
    step();
    a_valid = 1; a_we = 0; b_valid = 1; b_we = 0;
    repeat (13) step();
    a_valid = 0; b_valid = 0;
    repeat (3) step();
    run = 1; ctr = 16'd5;
    req_b(0, '0);
    req_b(1, 16'hFFFF);
    req_b(0, '0);
    run = 0;
    step();
    a_valid = 1; a_we = 1; a_wstrb = 2'b11; a_wdata = 16'hBEEF;
    step();
    reset = 1; a_valid = 0;
    step();
    reset = 0;
    step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    a_valid = 1; a_we = 0; b_valid = 1; b_we = 0;
    step();
    step();
    chk("rst_pref_a", 32'(grant), 32'h1);
    repeat (5) step();
    a_valid = 0; b_valid = 0;
    for (int c = 0; c < 400; c++) begin
      if (a_seen) a_valid = 0;
      else if (!a_valid && $urandom_range(0, 2) == 0) begin
        a_valid = 1; a_we = 1'($urandom); a_wstrb = 2'($urandom); a_wdata = 16'($urandom);
      end
      if (b_seen) b_valid = 0;
      else if (!b_valid && $urandom_range(0, 2) == 0) begin
        b_valid = 1; b_we = 1'($urandom); b_wdata = 16'($urandom);
      end
      run = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) ctr = 16'($urandom);
      reset = $urandom_range(0, 99) == 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter_req_arbiter.md
Name: counter_req_arbiter

Overview:
Controller that shares the user-area counter datapath between two requesters: port A (Wishbone-side: byte strobes) and port B (logic-analyzer-side: full-word writes).
- Arbitrates requests round-robin and sequences each access as a fixed 3-state transaction.
- Issues load and increment-enable commands to the counter and returns the sampled count with a one-cycle ready pulse.
- Sits between the Wishbone/LA glue and the counter register.

Parameters:
BITS, 16, counter and data width; must be a multiple of 8 and at least 8.
NSTRB, BITS/8, number of byte strobes on port A; derived, not overridden.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
run  input  1  free-running increment enable from configuration
a_valid  input  1  port A request
a_we  input  1  port A write (1) / read (0)
a_wstrb  input  NSTRB  port A byte write strobes
a_wdata  input  BITS  port A write data
a_ready  output  1  port A completion pulse
a_rdata  output  BITS  port A read data (pre-write count)
b_valid  input  1  port B request
b_we  input  1  port B write (1) / read (0)
b_wdata  input  BITS  port B write data (full word)
b_ready  output  1  port B completion pulse
b_rdata  output  BITS  port B read data (pre-write count)
cnt_value  input  BITS  current counter value
cnt_load  output  1  load strobe to counter
cnt_load_val  output  BITS  value to load
cnt_inc  output  1  increment enable to counter
busy  output  1  transaction in progress (state != IDLE)
grant  output  2  one-hot current/last owner {B,A}, debug

Behaviour:
- Reset (synchronous, active-high, clk rising edge) sets:
  - state = IDLE, rr_ptr = A-preferred.
  - a_ready = b_ready = 0, a_rdata = b_rdata = 0.
  - grant = 2'b00, cnt_load = 0.
- States: IDLE, SERVE, DONE.
- IDLE:
  - If no valid is high, stay in IDLE.
  - If exactly one valid is high, latch that port: owner, we, data, strobes. Go to SERVE.
  - If both are high, pick the port that rr_ptr prefers, latch it, go to SERVE. The loser stays pending; its valid must remain high.
- SERVE (exactly 1 cycle):
  - Register the owner's rdata <= cnt_value, sampled in this cycle before any load.
  - If the latched we = 1, assert cnt_load combinationally in SERVE.
    - Port A: cnt_load_val = cnt_value with byte i replaced by a_wdata byte i where a_wstrb[i] = 1.
    - Port B: cnt_load_val = b_wdata.
  - Port A write with all strobes 0: cnt_load = 0. The transaction still completes with ready.
  - Go to DONE.
- DONE (1 cycle):
  - Owner's ready = 1 for exactly this cycle; the other port's ready = 0.
  - rdata is stable from DONE until the next SERVE for that port.
  - Toggle rr_ptr so the other port is preferred next. Return to IDLE.
- Latency: valid high in IDLE at cycle 0 -> SERVE in cycle 1 -> ready in cycle 2. Minimum spacing between back-to-back grants is 3 cycles.
- A port that holds valid high through its own ready is treated as a new request in the following IDLE cycle. Requesters must drop valid in the cycle after ready.
- valid deasserted after acceptance (during SERVE or DONE): the transaction still completes and ready still pulses.
- cnt_inc = run & ~cnt_load. Load takes precedence; there is no increment in the load cycle. Reads do not suppress increments.
- cnt_value wrap-around (all 1s -> 0) is the counter's concern. The arbiter passes values through unchanged, with no saturation.
- grant: one-hot owner, set on entry to SERVE, held through DONE and IDLE until the next grant. Cleared only by reset.
- Reset asserted in SERVE or DONE: the in-flight transaction is aborted. No ready is pulsed. The port must re-request after reset.
- Single clock domain; there is no internal combinational path from a_valid or b_valid to any output.

Test Plan:
- A write, wstrb=2'b11, a_wdata=16'h1234, run=0 -> cnt_load=1 with cnt_load_val=16'h1234 in cycle 1; a_ready=1 in cycle 2; a_rdata = prior cnt_value.
- A write, wstrb=2'b10, a_wdata=16'hAB00, cnt_value=16'h00CD -> cnt_load_val=16'hABCD. A write with wstrb=2'b00 -> no cnt_load, a_ready still pulses.
- Both ports held valid (reads) continuously from reset -> grants in order A,B,A,B. Each ready comes 3 cycles apart with correct rdata.
- run=1, B read, cnt_value counting 5,6,7 -> cnt_inc stays high throughout. b_rdata = value seen in SERVE.
- run=1, B write 16'hFFFF -> cnt_inc=0 only in the SERVE cycle; cnt_load_val=16'hFFFF. The next read returns a wrapped value if the counter incremented.
- Reset pulsed during SERVE of an A write -> no a_ready pulse; state IDLE, grant=2'b00, outputs 0 next cycle. The next request resumes with A preferred.
